// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: downscaled VGA scan-out reads win; leftover slots go to two writers (round-robin).
// Optional clear engine built when FB_CLEAR_EN is defined.
module vga_fb_arbiter #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = H_ACTIVE >> SCALE_SHIFT,
  parameter int FB_H        = V_ACTIVE >> SCALE_SHIFT,
  parameter int AW          = 15,
  parameter int DW          = 8,
  parameter logic [DW-1:0] CLEAR_COLOR = '0
) (
  input  logic          clk_25,
  input  logic          rst_n,
  input  logic [9:0]    hs,
  input  logic [9:0]    vs,
  input  logic          w0_req,
  input  logic [AW-1:0] w0_addr,
  input  logic [DW-1:0] w0_data,
  output logic          w0_gnt,
  input  logic          w1_req,
  input  logic [AW-1:0] w1_addr,
  input  logic [DW-1:0] w1_data,
  output logic          w1_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pixel_o,
  output logic          active_o,
  input  logic          clear_req,
  output logic          clear_done
);

  localparam logic [9:0]    H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT   = 10'(V_ACTIVE);
  localparam logic [AW-1:0] FB_SIZE = AW'(FB_W * FB_H);
  localparam logic [AW-1:0] FB_LAST = AW'(FB_W * FB_H - 1);

  typedef enum logic [1:0] {NORMAL, CLR_WAIT, CLEAR} state_t;

  state_t        state, state_nxt;
  logic          in_active, rd_slot;
  logic [AW-1:0] rd_addr;
  logic          clearing;
  logic [AW-1:0] clr_addr;
  logic          last_gnt;
  logic          act_d1, act_d2, rd_d1;
  logic [DW-1:0] pix_q;

  assign in_active = (hs < H_ACT) && (vs < V_ACT);
  assign rd_slot   = in_active && (hs[SCALE_SHIFT-1:0] == '0);
  assign rd_addr   = AW'(vs >> SCALE_SHIFT) * AW'(FB_W) + AW'(hs >> SCALE_SHIFT);

  always_comb begin
    w0_gnt    = 1'b0;
    w1_gnt    = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rd_slot) begin
      mem_addr = rd_addr;
    end else if (rst_n) begin
      if (clearing) begin
        mem_addr  = clr_addr;
        mem_we    = 1'b1;
        mem_wdata = CLEAR_COLOR;
      end else if (w0_req && (!w1_req || last_gnt)) begin
        // last_gnt=1 means w1 was served last, so w0 takes a contested slot
        w0_gnt    = 1'b1;
        mem_addr  = w0_addr;
        mem_wdata = w0_data;
        mem_we    = (w0_addr < FB_SIZE);
      end else if (w1_req) begin
        w1_gnt    = 1'b1;
        mem_addr  = w1_addr;
        mem_wdata = w1_data;
        mem_we    = (w1_addr < FB_SIZE);
      end
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef FB_CLEAR_EN
    unique case (state)
      NORMAL:   if (clear_req) state_nxt = CLR_WAIT;
      CLR_WAIT: if (vs == V_ACT && hs == '0) state_nxt = CLEAR;
      CLEAR:    if (!rd_slot && clr_addr == FB_LAST) state_nxt = NORMAL;
      default:  state_nxt = NORMAL;
    endcase
`endif
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      state    <= NORMAL;
      last_gnt <= 1'b1;
      act_d1   <= 1'b0;
      act_d2   <= 1'b0;
      rd_d1    <= 1'b0;
      pix_q    <= '0;
    end else begin
      state  <= state_nxt;
      act_d1 <= in_active;
      act_d2 <= act_d1;
      rd_d1  <= rd_slot;
      if (w0_gnt)
        last_gnt <= 1'b0;
      else if (w1_gnt)
        last_gnt <= 1'b1;
      if (rd_d1)
        pix_q <= mem_rdata;
    end
  end

  assign active_o = act_d2;
  assign pixel_o  = act_d2 ? pix_q : '0;

`ifdef FB_CLEAR_EN
  logic clr_step;

  assign clearing = (state == CLEAR);
  assign clr_step = clearing && !rd_slot && rst_n;

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      clr_addr   <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (clr_step) begin
        if (clr_addr == FB_LAST) begin
          clr_addr   <= '0;
          clear_done <= 1'b1;
        end else begin
          clr_addr <= clr_addr + 1'b1;
        end
      end
    end
  end
`else
  logic unused_clear_req;

  assign clearing         = 1'b0;
  assign clr_addr         = '0;
  assign clear_done       = 1'b0;
  assign unused_clear_req = clear_req;
`endif

endmodule
